// File: rtl/acq_coh_accumulator.sv
// Coherent I/Q integrator: sums acc_len signed 6-bit mixer products per block and dumps each block.
// Latency: the edge that takes the last sample of a block also loads out_i/out_q and raises out_valid.
// Backpressure: none on the input. A dump onto an unaccepted result overwrites it and sets overrun.
// Optional feature: ACC_SATURATE_EN (saturating adds with a sticky saturated flag; otherwise the adds wrap).
module acq_coh_accumulator #(
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 continuous,
  input  logic [9:0]           acc_len,
  input  logic                 in_valid,
  input  logic [5:0]           in_i,
  input  logic [5:0]           in_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_i,
  output logic [ACC_WIDTH-1:0] out_q,
  output logic                 busy,
  output logic                 overrun,
  output logic                 saturated
);

  typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [ACC_WIDTH-1:0] acc_i, acc_q;
  logic [ACC_WIDTH-1:0] ext_i, ext_q;
  logic [ACC_WIDTH-1:0] sum_i, sum_q;
  logic [10:0]          cnt, len_r;
  logic                 cont_r;
  logic                 do_start, do_clear, do_add, do_dump;

  assign ext_i = {{(ACC_WIDTH-6){in_i[5]}}, in_i};
  assign ext_q = {{(ACC_WIDTH-6){in_q[5]}}, in_q};
  assign busy  = (state == S_ACC);

`ifdef ACC_SATURATE_EN
  logic sat_i, sat_q;

  // One guard bit catches the overflow; on overflow the sign of the wide sum picks the rail.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0]   w;
    logic [ACC_WIDTH-1:0] r;
    logic                 ovf;
    w   = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    ovf = w[ACC_WIDTH] ^ w[ACC_WIDTH-1];
    if (!ovf)           r = w[ACC_WIDTH-1:0];
    else if (w[ACC_WIDTH]) r = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else                r = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return {ovf, r};
  endfunction

  // Clamped running sums; the same clamped value feeds both the accumulator and the dump.
  always_comb begin
    {sat_i, sum_i} = sat_add(acc_i, ext_i);
    {sat_q, sum_q} = sat_add(acc_q, ext_q);
  end

  // Sticky clamp flag, cleared by start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       saturated <= 1'b0;
    else if (do_start)                             saturated <= 1'b0;
    else if ((do_add || do_dump) && (sat_i || sat_q)) saturated <= 1'b1;
  end
`else
  assign sum_i     = acc_i + ext_i;
  assign sum_q     = acc_q + ext_q;
  assign saturated = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath strobes; stop beats start, start beats a sample in the same cycle.
  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_clear  = 1'b0;
    do_add    = 1'b0;
    do_dump   = 1'b0;
    if (stop) begin
      state_nxt = S_IDLE;
      do_clear  = 1'b1;
    end else if (start) begin
      state_nxt = S_ACC;
      do_start  = 1'b1;
      do_clear  = 1'b1;
    end else if (state == S_ACC && in_valid) begin
      if (cnt == len_r - 11'd1) begin
        do_dump   = 1'b1;
        do_clear  = 1'b1;
        state_nxt = cont_r ? S_ACC : S_IDLE;
      end else begin
        do_add = 1'b1;
      end
    end
  end

  // Accumulators, sample counter and the block configuration captured at start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_i  <= '0;
      acc_q  <= '0;
      cnt    <= '0;
      len_r  <= 11'd1024;
      cont_r <= 1'b0;
    end else begin
      if (do_clear) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
      end else if (do_add) begin
        acc_i <= sum_i;
        acc_q <= sum_q;
        cnt   <= cnt + 11'd1;
      end
      if (do_start) begin
        len_r  <= (acc_len == 10'd0) ? 11'd1024 : {1'b0, acc_len};
        cont_r <= continuous;
      end
    end
  end

  // Output register with valid/ready handshake; a dump always wins over a pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      overrun   <= 1'b0;
    end else begin
      if (do_dump) begin
        out_i     <= sum_i;
        out_q     <= sum_q;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (do_start) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acq_coh_accumulator.sv
module tb_acq_coh_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start12 = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic [9:0]  acc_len = '0;
  logic        in_valid = 1'b0;
  logic [5:0]  in_i = '0, in_q = '0;
  logic        out_ready = 1'b1;
  logic        out_valid, busy, overrun, saturated;
  logic [15:0] out_i, out_q;
  logic        out_valid12, busy12, overrun12, saturated12;
  logic [11:0] out_i12, out_q12;

  acq_coh_accumulator #(.ACC_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .acc_len(acc_len), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
    .busy(busy), .overrun(overrun), .saturated(saturated));

  acq_coh_accumulator #(.ACC_WIDTH(12)) u_dut12 (
    .clk(clk), .rst(rst), .start(start12), .stop(stop), .continuous(continuous),
    .acc_len(acc_len), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .out_valid(out_valid12), .out_ready(out_ready), .out_i(out_i12), .out_q(out_q12),
    .busy(busy12), .overrun(overrun12), .saturated(saturated12));

  always #5 clk = ~clk;

  typedef struct {int i; int q;} res_t;
  res_t exp_q[$];

  int n_cmp = 0, n_err = 0;
  int mdl_i, mdl_q, mdl_cnt, mdl_len, n_dumps;
  bit mdl_busy, mdl_cont, mdl_vld, mdl_ovr;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  // One clock cycle of stimulus, followed by a reference-model update and checks #1 after the edge.
  task automatic cyc(input bit st, input bit sp, input bit v, input int i, input int q);
    bit   dump;
    res_t e;
    start = st; stop = sp; in_valid = v; in_i = i[5:0]; in_q = q[5:0];
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    dump = 1'b0;
    if (sp) begin
      mdl_busy = 1'b0; mdl_i = 0; mdl_q = 0; mdl_cnt = 0;
    end else if (st) begin
      mdl_busy = 1'b1; mdl_i = 0; mdl_q = 0; mdl_cnt = 0; mdl_ovr = 1'b0;
      mdl_len  = (acc_len == 10'd0) ? 1024 : int'(acc_len);
      mdl_cont = continuous;
    end else if (mdl_busy && v) begin
      mdl_i += i; mdl_q += q; mdl_cnt++;
      if (mdl_cnt == mdl_len) begin
        dump = 1'b1;
        exp_q.push_back('{wrap16(mdl_i), wrap16(mdl_q)});
        mdl_i = 0; mdl_q = 0; mdl_cnt = 0;
        mdl_busy = mdl_cont;
      end
    end
    if (dump) begin
      if (mdl_vld && !out_ready) mdl_ovr = 1'b1;
      mdl_vld = 1'b1;
      n_dumps++;
    end else if (mdl_vld && out_ready) begin
      mdl_vld = 1'b0;
    end
    check("out_valid", out_valid, mdl_vld);
    check("busy", busy, mdl_busy);
    check("overrun", overrun, mdl_ovr);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dump_i", $signed(out_i), e.i);
      check("dump_q", $signed(out_q), e.q);
    end
  endtask

  task automatic begin_block(input int len, input bit cont);
    acc_len = len[9:0]; continuous = cont;
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    mdl_i = 0; mdl_q = 0; mdl_cnt = 0; mdl_len = 1024; n_dumps = 0;
    mdl_busy = 0; mdl_cont = 0; mdl_vld = 0; mdl_ovr = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_i", out_i, 0);
    check("rst_out_q", out_q, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_saturated", saturated, 0);
    rst = 1'b0;

    // One-shot sum of four samples
    out_ready = 1'b1;
    begin_block(4, 1'b0);
    cyc(0, 0, 1, 5, -3);
    cyc(0, 0, 1, 31, -32);
    cyc(0, 0, 1, -7, 2);
    cyc(0, 0, 1, 1, 1);
    check("oneshot_i", $signed(out_i), 30);
    check("oneshot_q", $signed(out_q), -32);
    check("oneshot_valid", out_valid, 1);
    cyc(0, 0, 0, 0, 0);
    check("oneshot_busy_after", busy, 0);
    cyc(0, 0, 1, 9, 9);  // ignored in IDLE

    // Continuous, gapped, no consumer
    out_ready = 1'b0;
    begin_block(3, 1'b1);
    for (int k = 0; k < 9; k++) begin
      repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 2, -1);
      if (k == 2) begin
        check("cont_first_i", $signed(out_i), 6);
        check("cont_first_q", $signed(out_q), -3);
        check("cont_first_ovr", overrun, 0);
      end
    end
    check("cont_overrun", overrun, 1);
    check("cont_valid_held", out_valid, 1);
    out_ready = 1'b1;
    cyc(0, 0, 0, 0, 0);
    check("cont_valid_drop", out_valid, 0);
    check("cont_overrun_sticky", overrun, 1);
    cyc(0, 1, 0, 0, 0);

    // acc_len = 0 means 1024 samples
    n_dumps = 0;
    begin_block(0, 1'b0);
    for (int k = 0; k < 1024; k++) cyc(0, 0, 1, 1, 1);
    check("len1024_dumps", n_dumps, 1);
    check("len1024_i", $signed(out_i), 1024);
    check("len1024_q", $signed(out_q), 1024);

    // acc_len = 1: dump on every sample
    n_dumps = 0;
    begin_block(1, 1'b1);
    for (int k = 1; k <= 6; k++) cyc(0, 0, 1, k, -k);
    check("len1_dumps", n_dumps, 6);
    cyc(0, 1, 0, 0, 0);

    // Stop mid-block, then a fresh start sums from zero
    begin_block(4, 1'b0);
    cyc(0, 0, 1, 7, 7);
    cyc(0, 0, 1, 7, 7);
    cyc(0, 1, 1, 7, 7);
    check("stop_busy", busy, 0);
    check("stop_no_valid", out_valid, 0);
    begin_block(4, 1'b0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 2, 2);
    check("after_stop_i", $signed(out_i), 8);

    // Restart while accumulating: config re-sampled, that cycle's sample dropped
    begin_block(6, 1'b0);
    cyc(0, 0, 1, 3, 3);
    cyc(0, 0, 1, 3, 3);
    acc_len = 10'd4;
    cyc(1, 0, 1, 9, 9);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1, 2);
    check("restart_i", $signed(out_i), 4);
    check("restart_q", $signed(out_q), 8);

    // start and stop together: stop wins
    cyc(1, 1, 0, 0, 0);
    check("start_stop_busy", busy, 0);

    // Overflow on the 12-bit instance
    acc_len = 10'd200; continuous = 1'b0; out_ready = 1'b1;
    start12 = 1'b1;
    @(posedge clk); #1;
    start12 = 1'b0;
    for (int k = 0; k < 200; k++) cyc(0, 0, 1, 31, 0);
    check("ovf_valid", out_valid12, 1);
`ifdef ACC_SATURATE_EN
    check("ovf_i", $signed(out_i12), 2047);
    check("ovf_sat", saturated12, 1);
`else
    check("ovf_i", $signed(out_i12), -1992);
    check("ovf_sat", saturated12, 0);
`endif
    check("ovf_q", $signed(out_q12), 0);
    check("main_sat", saturated, 0);

    // Asynchronous reset mid-block with a pending result
    out_ready = 1'b0;
    begin_block(2, 1'b1);
    cyc(0, 0, 1, 5, 6);
    cyc(0, 0, 1, 5, 6);
    cyc(0, 0, 1, 5, 6);
    check("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_i", out_i, 0);
    check("arst_q", out_q, 0);
    check("arst_busy", busy, 0);
    check("arst_overrun", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/acq_coh_accumulator.md
# acq_coh_accumulator

Coherent integrator that sits directly downstream of the acquisition engine's 4-bit sign/magnitude complex carrier mixer. Each cycle it takes one signed 6-bit I/Q mixer product, sums a programmable number of products into wide I/Q accumulators, and dumps each completed block to a registered output with a valid/ready handshake. It supports one-shot or continuous operation and flags output overruns.

## Interface
- ACC_WIDTH, 16: accumulator and output width in bits, two's complement; legal range 12..24.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; clears the accumulators and counter, then enters ACC.
- stop  input  1  single-cycle pulse; aborts and returns to IDLE; the partial sum is discarded.
- continuous  input  1  sampled at start; 1 = re-arm after each dump, 0 = stop after one dump.
- acc_len  input  10  samples per block, sampled at start; 0 means 1024.
- in_valid  input  1  in_i/in_q carry a valid product this cycle.
- in_i  input  6  signed two's complement I product from the mixer.
- in_q  input  6  signed two's complement Q product from the mixer.
- out_valid  output  1  dump result available.
- out_ready  input  1  consumer accepts the result when out_valid=1.
- out_i  output  ACC_WIDTH  dumped I sum.
- out_q  output  ACC_WIDTH  dumped Q sum.
- busy  output  1  1 while in the ACC state.
- overrun  output  1  sticky; a dump occurred while the previous result was still unaccepted.
- saturated  output  1  sticky; only present with ACC_SATURATE_EN, otherwise tied to 0.

## Operation
- States: IDLE and ACC.
- IDLE -> ACC on start. On entry: acc_i = acc_q = 0, cnt = 0, len_r = acc_len (0 maps to 1024), cont_r = continuous. start also clears overrun and saturated.
- In ACC with in_valid=1: sign-extend in_i/in_q to ACC_WIDTH and add them to acc_i/acc_q; cnt increments.
- Dump: the in_valid cycle with cnt == len_r-1.
  - out_i/out_q <= acc + current sample, so the last sample is included.
  - out_valid <= 1; acc <= 0; cnt <= 0.
  - Next state: ACC if cont_r=1, else IDLE.
- Cycles with in_valid=0 change nothing; gaps are allowed anywhere.
- Handshake: out_valid stays high and out_i/out_q stay stable until a cycle with out_valid & out_ready, after which out_valid drops on the next edge.
- Dump with out_valid=1 and out_ready=0 in the same cycle: the new result overwrites the old one, out_valid stays 1, overrun <= 1.
- Dump with out_ready=1 in the same cycle: the new result loads, out_valid stays 1, no overrun.
- stop in ACC: go to IDLE; acc and cnt cleared; any pending out_valid/out_i/out_q untouched.
- stop and start in the same cycle: stop wins, end in IDLE.
- start while in ACC: restart. Acc/cnt cleared, config re-sampled, a sample presented that cycle is discarded, pending output kept.
- Arithmetic without the macro: accumulators wrap modulo 2^ACC_WIDTH.

## Timing
- Reset values: out_valid=0, out_i=0, out_q=0, busy=0, overrun=0, saturated=0, state IDLE, acc=0, cnt=0.
- Throughput: 1 sample per cycle.
- Latency: the last sample's edge to out_valid=1 is 1 cycle (registered output).
- busy rises on the edge after start. It falls on the edge after the final dump (one-shot) or after stop.
- Continuous mode: the sample in the cycle after a dump is accumulated into the next block with no bubble.
- An asserted rst at any point, including mid-block, immediately forces the reset values; a pending output is lost.

## Configuration
- ACC_SATURATE_EN defined:
  - Each add clamps to +(2^(ACC_WIDTH-1)-1) or -(2^(ACC_WIDTH-1)).
  - saturated is set sticky when clamping occurs on I or Q.
  - The clamped value is used for the dump.
- ACC_SATURATE_EN undefined: two's complement wrap; saturated constant 0; no clamp logic.

## Test plan
- One-shot sum:
  - Stimulus: reset; start with acc_len=4, continuous=0; samples (in_i,in_q) = (5,-3),(31,-32),(-7,2),(1,1).
  - Response: one cycle after the 4th sample, out_valid=1, out_i=30, out_q=-32; busy=0 afterwards.
- Continuous, gapped input, back-pressure:
  - Stimulus: acc_len=3, continuous=1, out_ready=0; nine samples of (2,-1) with random in_valid gaps.
  - Response: first dump out_i=6, out_q=-3. Second and third dumps set overrun=1 and keep out_valid=1. Raising out_ready clears out_valid next edge.
- acc_len=0:
  - Stimulus: 1024 samples of (1,1).
  - Response: a single dump out_i=out_q=1024.
  - Stimulus: the same with acc_len=1.
  - Response: a dump after every sample.
- Abort and restart:
  - Stimulus: stop mid-block.
  - Response: busy=0, no out_valid, next start sums from 0.
  - Stimulus: start and stop in the same cycle.
  - Response: IDLE.
  - Stimulus: assert rst mid-block with out_valid=1.
  - Response: all outputs 0.
- Overflow, ACC_WIDTH=12, acc_len=200, in_i=31:
  - With the macro: out_i=2047, saturated=1.
  - Without it: out_i = 6200 mod 4096 = 2104 read as signed = -1992.
